// File: rtl/sign_mag_pkg.sv
// Shared constants and helpers for the sign-magnitude add/subtract pipeline.
// Feature macro used by the top: SIGN_MAG_SATURATE_EN (saturate instead of wrap).
package sign_mag_pkg;

    localparam int unsigned SM_W_MAX = 64;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Magnitude bits of an n-bit sign-magnitude word (word zero-extended to SM_W_MAX).
    function automatic logic [SM_W_MAX-1:0] mag_of(input logic [SM_W_MAX-1:0] word,
                                                   input int unsigned n);
        return word & ((64'd1 << (n - 32'd1)) - 64'd1);
    endfunction

    // Canonical sign: a zero magnitude is always reported as positive.
    function automatic logic canon(input logic sign, input logic [SM_W_MAX-1:0] mag);
        return (mag == '0) ? 1'b0 : sign;
    endfunction

endpackage

// File: rtl/sign_mag_cmp.sv
// Stage S1 decode: orders the two magnitudes and picks the result sign.
// Negative-zero operands fall out naturally as magnitude 0.
module sign_mag_cmp
    import sign_mag_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         op_i,
    output logic [N-2:0] max_o,
    output logic [N-2:0] min_o,
    output logic         sign_o,
    output logic         same_o
);

    logic [N-2:0] mag_a_s;
    logic [N-2:0] mag_b_s;
    logic         sb_s;

    assign mag_a_s = (N-1)'(mag_of(SM_W_MAX'(a_i), N));
    assign mag_b_s = (N-1)'(mag_of(SM_W_MAX'(b_i), N));
    assign sb_s    = b_i[N-1] ^ (op_i == OP_SUB);
    assign same_o  = (a_i[N-1] == sb_s);

    // Larger magnitude dictates the sign; ties take B's effective sign.
    always_comb begin
        max_o  = mag_b_s;
        min_o  = mag_a_s;
        sign_o = sb_s;
        if (mag_a_s > mag_b_s) begin
            max_o  = mag_a_s;
            min_o  = mag_b_s;
            sign_o = a_i[N-1];
        end else begin
            max_o  = mag_b_s;
            min_o  = mag_a_s;
            sign_o = sb_s;
        end
    end

endmodule

// File: rtl/sign_mag_addsub_pipe.sv
// Two-stage sign-magnitude add/subtract with valid/ready flow control and overflow counter.
// Define SIGN_MAG_SATURATE_EN to clamp overflowed magnitudes to all-ones instead of wrapping.
module sign_mag_addsub_pipe
    import sign_mag_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             ovf,
    output logic             zero,
    output logic [CNT_W-1:0] ovf_cnt
);

    logic             en_s;
    logic [N-2:0]     s1_max_d, s1_min_d;
    logic             s1_sign_d, s1_same_d;
    logic             s1_valid_q;
    logic [N-2:0]     s1_max_q, s1_min_q;
    logic             s1_sign_q, s1_same_q;
    logic [N-1:0]     add_s;
    logic [N-2:0]     mag_raw_s, mag_s;
    logic             carry_s;
    logic [N-1:0]     sum_d;
    logic             ovf_d, zero_d;
    logic             out_valid_q;
    logic [N-1:0]     sum_q;
    logic             ovf_q, zero_q;
    logic [CNT_W-1:0] ovf_cnt_q;

    // Whole pipe advances together unless a held result is being refused.
    assign en_s     = !out_valid_q || out_ready;
    assign in_ready = en_s;

    sign_mag_cmp #(.N(N)) u_cmp (
        .a_i    (a),
        .b_i    (b),
        .op_i   (op),
        .max_o  (s1_max_d),
        .min_o  (s1_min_d),
        .sign_o (s1_sign_d),
        .same_o (s1_same_d)
    );

    // S1 register: ordered magnitudes and sign decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_max_q   <= '0;
            s1_min_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_same_q  <= 1'b0;
        end else if (en_s) begin
            s1_valid_q <= in_valid;
            s1_max_q   <= s1_max_d;
            s1_min_q   <= s1_min_d;
            s1_sign_q  <= s1_sign_d;
            s1_same_q  <= s1_same_d;
        end
    end

    assign add_s = {1'b0, s1_max_q} + {1'b0, s1_min_q};

    // S2 arithmetic: max >= min, so the subtract path can never borrow.
    always_comb begin
        carry_s   = 1'b0;
        mag_raw_s = '0;
        if (s1_same_q) begin
            carry_s   = add_s[N-1];
            mag_raw_s = add_s[N-2:0];
        end else begin
            carry_s   = 1'b0;
            mag_raw_s = s1_max_q - s1_min_q;
        end
    end

`ifdef SIGN_MAG_SATURATE_EN
    assign mag_s = carry_s ? {(N-1){1'b1}} : mag_raw_s;
`else
    assign mag_s = mag_raw_s;
`endif

    assign sum_d  = {canon(s1_sign_q, SM_W_MAX'(mag_s)), mag_s};
    assign zero_d = (mag_s == '0);
    assign ovf_d  = carry_s;

    // S2 register: drives the result ports directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (en_s) begin
            out_valid_q <= s1_valid_q;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    // Overflow-event counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else if (out_valid_q && out_ready && ovf_q && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_sign_mag_addsub_pipe.sv
// Scoreboard bench for sign_mag_addsub_pipe: directed plan cases plus randomized traffic.
module tb_sign_mag_addsub_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       op = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;

    logic       in_ready, out_valid, ovf, zero;
    logic [7:0] sum, ovf_cnt;
    logic       in_ready2, out_valid2, ovf2, zero2;
    logic [7:0] sum2;
    logic [1:0] ovf_cnt2;

    logic [9:0] sb_q[$];
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int exp_cnt2 = 0;
    bit rnd_ready = 1'b0;

    sign_mag_addsub_pipe #(.N(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .ovf(ovf), .zero(zero), .ovf_cnt(ovf_cnt)
    );

    sign_mag_addsub_pipe #(.N(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
        .sum(sum2), .ovf(ovf2), .zero(zero2), .ovf_cnt(ovf_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: signed integer arithmetic on the decoded operands; returns {ovf, zero, sum}.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mop);
        int va, vb, r, m;
        logic ov, s;
        va = ma[7] ? -int'(ma[6:0]) : int'(ma[6:0]);
        vb = mb[7] ? -int'(mb[6:0]) : int'(mb[6:0]);
        r  = mop ? (va - vb) : (va + vb);
        m  = (r < 0) ? -r : r;
        ov = (m > 127);
`ifdef SIGN_MAG_SATURATE_EN
        if (ov) m = 127;
`else
        m = m % 128;
`endif
        s = (r < 0) && (m != 0);
        return {ov, (m == 0), s, m[6:0]};
    endfunction

    // Present one operand pair, wait for acceptance, record the expected response.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic top, input logic [9:0] exp);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(exp);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL in_ready_timeout: got in_ready=0 for 50 cycles expected acceptance");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare presented results with the scoreboard head, pop on transfer.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("ovf_cnt", ovf_cnt, exp_cnt);
                check("ovf_cnt_w2", ovf_cnt2, exp_cnt2);
                check("in_ready", in_ready, !out_valid || out_ready);
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got sum=0x%0h with nothing outstanding", sum);
                    end else begin
                        e = sb_q[0];
                        check("result", {ovf, zero, sum}, e);
                        check("result_w2", {out_valid2, ovf2, zero2, sum2}, {1'b1, e});
                        if (out_ready) begin
                            void'(sb_q.pop_front());
                            if (e[9]) begin
                                if (exp_cnt < 255) exp_cnt++;
                                if (exp_cnt2 < 3) exp_cnt2++;
                            end
                        end
                    end
                end
            end
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected $finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rop;
        logic [9:0] e_100_50, e_7f_7f, e_c0_c0, e_ff_7f;
`ifdef SIGN_MAG_SATURATE_EN
        e_100_50 = {2'b10, 8'h7F};
        e_7f_7f  = {2'b10, 8'h7F};
        e_c0_c0  = {2'b10, 8'hFF};
        e_ff_7f  = {2'b10, 8'hFF};
`else
        e_100_50 = {2'b10, 8'h16};
        e_7f_7f  = {2'b10, 8'h7E};
        e_c0_c0  = {2'b11, 8'h00};
        e_ff_7f  = {2'b10, 8'hFE};
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_ovf", ovf, 0);
        check("rst_zero", zero, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Latency: result appears two cycles after the handshake cycle.
        out_ready = 1'b1;
        send(8'h05, 8'h83, 1'b0, {2'b00, 8'h02});
        @(negedge clk);
        check("lat_cycle1", out_valid, 0);
        @(negedge clk);
        check("lat_cycle2", out_valid, 1);
        @(posedge clk); #1;

        send(8'h05, 8'h83, 1'b1, {2'b00, 8'h08});
        send(8'h83, 8'h05, 1'b1, {2'b00, 8'h88});
        send(8'h64, 8'h32, 1'b0, e_100_50);
        send(8'h87, 8'h07, 1'b0, {2'b01, 8'h00});
        send(8'h80, 8'h00, 1'b1, {2'b01, 8'h00});
        idle(4);
        @(negedge clk);
        check("ovf_cnt_after_100_50", ovf_cnt, 1);
        @(posedge clk); #1;

        // Backpressure: consumer stalls while four pairs are streamed.
        out_ready = 1'b0;
        fork
            begin
                send(8'h01, 8'h02, 1'b0, {2'b00, 8'h03});
                send(8'h85, 8'h03, 1'b1, {2'b00, 8'h88});
                send(8'h7F, 8'h7F, 1'b1, {2'b01, 8'h00});
                send(8'h10, 8'h90, 1'b0, {2'b01, 8'h00});
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(4);

        // Five overflowing results: narrow counter saturates at 3.
        send(8'h7F, 8'h7F, 1'b0, e_7f_7f);
        send(8'h7F, 8'h7F, 1'b0, e_7f_7f);
        send(8'hC0, 8'hC0, 1'b0, e_c0_c0);
        send(8'hFF, 8'h7F, 1'b1, e_ff_7f);
        send(8'h7F, 8'h7F, 1'b0, e_7f_7f);
        idle(4);
        @(negedge clk);
        check("ovf_cnt_six", ovf_cnt, 6);
        check("ovf_cnt_w2_sat", ovf_cnt2, 3);
        @(posedge clk); #1;

        // Reset with both stages full: nothing in flight survives.
        out_ready = 1'b0;
        send(8'h05, 8'h83, 1'b0, {2'b00, 8'h02});
        send(8'h64, 8'h32, 1'b0, e_100_50);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        exp_cnt = 0;
        exp_cnt2 = 0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_ovf_cnt", ovf_cnt, 0);
        check("midrst_ovf_cnt_w2", ovf_cnt2, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(4);

        // Randomized traffic with random backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rb = {rb[7], ra[6:0]};
            send(ra, rb, rop, model(ra, rb, rop));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
        idle(2);
        check("drain_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
